uart_tx_buffered: RTL and testbench

Memory-mapped UART transmitter with a write FIFO, placed downstream of the master memory map as the UART slave. The core stores bytes through the map's slave write port; the block queues them and serialises them as 8N1 frames on `tx` without stalling the pipeline. Status and baud-divider registers are readable through the same slave port.

---
 rtl/uart_tx_buffered.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Memory-mapped 8N1 UART transmitter with a write FIFO and status/baud registers.
// Build option: define UART_TX_PARITY_EN to append an even-parity bit to each frame.
module uart_tx_buffered #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int DEFAULT_DIV = 433
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [31:0]           address,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  tx,
  output logic                  o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          ovf_reg;
  logic [15:0]   clkdiv_reg;

  state_t        state_reg, state_next;
  logic [15:0]   timer_reg, timer_next;
  logic [15:0]   bit_div_reg, bit_div_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg;
  logic          tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
  logic          parity_reg;
`endif

  logic [1:0] reg_sel;
  logic       empty, full, push_req, push, pop, shift_en;
  logic       unused_bits;

  assign reg_sel  = address[3:2];
  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign push_req = we && (reg_sel == 2'd0);
  // A full FIFO rejects the push even if the FSM frees a slot this cycle.
  assign push     = push_req && !full;

  assign unused_bits = ^{re, address[31:4], address[1:0], wd};

  // FIFO bookkeeping and control registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      clkdiv_reg <= 16'(DEFAULT_DIV);
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
      if (push_req && full)
        ovf_reg <= 1'b1;
      else if (we && (reg_sel == 2'd1) && wd[3])
        ovf_reg <= 1'b0;
      if (we && (reg_sel == 2'd2))
        clkdiv_reg <= wd[15:0];
    end
  end

  // Storage and registered read into the shifter; no reset so it maps to RAM.
  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr_reg] <= wd[7:0];
    if (pop) begin
      shift_reg  <= mem[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
      parity_reg <= ^mem[rd_ptr_reg];
`endif
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_div_reg <= 16'(DEFAULT_DIV);
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_div_reg <= bit_div_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_div_next = bit_div_reg;
    bit_idx_next = bit_idx_reg;
    pop          = 1'b0;
    shift_en     = 1'b0;
    tx_next      = 1'b1;

    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          state_next   = START;
          timer_next   = clkdiv_reg;
          bit_div_next = clkdiv_reg;
        end
      end
      START: begin
        if (timer_reg == '0) begin
          state_next   = DATA;
          bit_idx_next = '0;
          timer_next   = bit_div_reg;
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end
      DATA: begin
        if (timer_reg == '0) begin
          timer_next = bit_div_reg;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            shift_en     = 1'b1;
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (timer_reg == '0) begin
          state_next = STOP;
          timer_next = bit_div_reg;
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end
`endif
      STOP: begin
        if (timer_reg == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop          = 1'b1;
            state_next   = START;
            timer_next   = clkdiv_reg;
            bit_div_next = clkdiv_reg;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_reg - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level follows the state being entered, so tx is fully registered.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_en ? shift_reg[1] : shift_reg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_reg;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_comb begin
    rd = '0;
    case (reg_sel)
      2'd1: begin
        rd[0]      = empty;
        rd[1]      = full;
        rd[2]      = (state_reg != IDLE);
        rd[3]      = ovf_reg;
        rd[8 +: CW] = count_reg;
      end
      2'd2:    rd[15:0] = clkdiv_reg;
      default: rd = '0;
    endcase
  end

  assign tx     = tx_reg;
  assign o_busy = !empty || (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered: register vectors plus frame-timing sequences.
module tb_uart_tx_buffered;

`ifdef UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] wd;
  logic [31:0] address;
  logic        we;
  logic        re;
  logic [31:0] rd;
  logic        tx;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  uart_tx_buffered #(
    .DATA_WIDTH (32),
    .DEPTH      (8),
    .DEFAULT_DIV(433)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .wd     (wd),
    .address(address),
    .we     (we),
    .re     (re),
    .rd     (rd),
    .tx     (tx),
    .o_busy (o_busy)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic reset_dut();
    i_rst = 1'b1; we = 1'b0; re = 1'b0; address = '0; wd = '0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a; wd = d; we = 1'b1;
    tick();
    we = 1'b0;
    $display("write addr=0x%0h data=0x%0h", a, d);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    address = a; re = 1'b1;
    #1;
    chk(name, rd, exp);
    $display("read  addr=0x%0h data=0x%0h expect=0x%0h", a, rd, exp);
    re = 1'b0;
  endtask

  // Expected line level for bit slot j of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == 9 && FBITS == 11) return ^b;
    return 1'b1;
  endfunction

  // Writes n bytes on consecutive cycles (first at edge E0) and checks tx every cycle.
  task automatic send_frames(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int div);
    logic [7:0] bytes [3];
    int bt, fl, total, f, j;
    bytes = '{b0, b1, b2};
    bt    = div + 1;
    fl    = FBITS * bt;
    total = n * fl;
    address = 32'h0; wd = {24'h0, b0}; we = 1'b1;
    for (int k = 0; k <= total + 1; k++) begin
      tick();
      if (k + 1 < n) begin
        wd = {24'h0, bytes[k+1]};
      end else begin
        we = 1'b0;
        address = 32'h4;
      end
      if (k == 0) begin
        chk("tx_idle_after_write", tx, 1);
      end else if (k <= total) begin
        f = (k - 1) / fl;
        j = ((k - 1) % fl) / bt;
        chk($sformatf("tx_frame%0d_slot%0d_cyc%0d", f, j, k), tx, exp_bit(bytes[f], j));
      end else begin
        chk("tx_after_frames", tx, 1);
      end
      if (k == total) chk("busy_last_cycle", o_busy, 1);
      if (k == total + 1) begin
        chk("busy_fall", o_busy, 0);
        #1;
        chk("status_after_frames", rd, 32'h1);
      end
    end
    $display("frames n=%0d div=%0d first=0x%0h cycles=%0d", n, div, b0, total);
  endtask

  vec_t vecs [14];
  int   lows;
  int   pop_k;

  initial begin
    vecs[0]  = '{0, 32'h4,    32'h0,        32'h0000_0001, "rst_status"};
    vecs[1]  = '{0, 32'h8,    32'h0,        32'd433,       "rst_clkdiv"};
    vecs[2]  = '{0, 32'h0,    32'h0,        32'h0,         "txdata_reads_zero"};
    vecs[3]  = '{0, 32'hC,    32'h0,        32'h0,         "rsvd_reads_zero"};
    vecs[4]  = '{1, 32'h8,    32'hFFFF_1234, 32'h0,        "wr_clkdiv"};
    vecs[5]  = '{0, 32'h8,    32'h0,        32'h0000_1234, "clkdiv_upper_zero"};
    vecs[6]  = '{1, 32'hC,    32'hFFFF_FFFF, 32'h0,        "wr_rsvd"};
    vecs[7]  = '{0, 32'hC,    32'h0,        32'h0,         "rsvd_after_write"};
    vecs[8]  = '{1, 32'h4,    32'hFFFF_FFFF, 32'h0,        "wr_status"};
    vecs[9]  = '{0, 32'h4,    32'h0,        32'h0000_0001, "status_after_write"};
    vecs[10] = '{0, 32'h1008, 32'h0,        32'h0000_1234, "addr_alias"};
    vecs[11] = '{1, 32'h8,    32'h3,        32'h0,         "wr_clkdiv3"};
    vecs[12] = '{0, 32'h8,    32'h0,        32'h0000_0003, "clkdiv_is_3"};
    vecs[13] = '{0, 32'h4,    32'h0,        32'h0000_0001, "status_idle"};

    reset_dut();
    chk("rst_tx", tx, 1);
    chk("rst_busy", o_busy, 0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
      else rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // Single byte at CLKDIV=3
    send_frames(1, 8'hA5, 8'h00, 8'h00, 3);

    // Back-to-back bytes at CLKDIV=0
    wr(32'h8, 32'h0);
    send_frames(3, 8'h01, 8'h02, 8'h03, 0);

    // Overflow: 10 writes from edge E0; first byte popped at E1, the tenth is dropped.
    reset_dut();
    wr(32'h8, 32'd100);
    address = 32'h0; wd = 32'h10; we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 9) wd = 32'h11 + i;
    end
    we = 1'b0;
    rd_chk("status_full_ovf", 32'h4, 32'h0000_080E);
    wr(32'h4, 32'h8);
    rd_chk("status_ovf_cleared", 32'h4, 32'h0000_0806);
    // Next pop happens on the edge after the first frame's last cycle.
    pop_k = FBITS * 101 + 1;
    for (int k = 11; k < pop_k; k++) tick();
    chk("stop_bit_before_pop", tx, 1);
    address = 32'h0; wd = 32'h99; we = 1'b1;
    tick();
    we = 1'b0;
    chk("next_start_bit", tx, 0);
    rd_chk("push_pop_when_full", 32'h4, 32'h0000_070C);

    // Mid-frame reset during data bit 3 (CLKDIV=3, cycles 17..20 after the write edge)
    reset_dut();
    wr(32'h8, 32'h3);
    address = 32'h0; wd = 32'h0; we = 1'b1;
    tick();
    wd = 32'h0;
    tick();
    we = 1'b0;
    for (int k = 2; k <= 18; k++) tick();
    chk("bit3_tx_low", tx, 0);
    chk("bit3_busy", o_busy, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("rst_mid_tx_high", tx, 1);
    chk("rst_mid_busy", o_busy, 0);
    rd_chk("rst_mid_status", 32'h4, 32'h0000_0001);
    rd_chk("rst_mid_clkdiv", 32'h8, 32'd433);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    chk("no_frame_after_reset", lows, 0);
    $display("mid-frame reset observed tx low cycles=%0d", lows);

`ifdef UART_TX_PARITY_EN
    wr(32'h8, 32'h0);
    send_frames(1, 8'h07, 8'h00, 8'h00, 0);
    send_frames(1, 8'h03, 8'h00, 8'h00, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
